// File: rtl/sub16_pkg.sv
// Shared types and sizing for the sequential digit-serial subtractor.
package sub16_pkg;

  localparam int SUB_WIDTH  = 16;
  localparam int SUB_DIGIT  = 4;
  localparam int SUB_DIGITS = SUB_WIDTH / SUB_DIGIT;
  localparam int SUB_CNT_W  = (SUB_DIGITS > 1) ? $clog2(SUB_DIGITS) : 1;

  // Operation lifecycle: waiting for operands, subtracting slices, holding result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/subtractor_16bit_seq_sub_digit.sv
// One DIGIT-bit slice of a - b - borrow, done as a + ~b + ~borrow so the
// carry out of the slice is the inverse of the borrow out.
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_s,
  input  logic [DIGIT-1:0] b_s,
  input  logic             bin,
  output logic [DIGIT-1:0] d_s,
  output logic             bout
);

  logic [DIGIT:0] sum;

  // Widen to DIGIT+1 bits so the carry lands in the top bit.
  always_comb begin
    sum  = {1'b0, a_s} + {1'b0, ~b_s} + {{DIGIT{1'b0}}, ~bin};
    d_s  = sum[DIGIT-1:0];
    bout = ~sum[DIGIT];
  end

endmodule

// File: rtl/subtractor_16bit_seq.sv
// Sequential subtractor: diff = a - b - bin, one DIGIT-bit slice per clock,
// LSB first. Operand and result ports use valid/ready handshakes.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. A producer holding valid keeps its data
// stable until that edge; ready never depends combinationally on valid.
module subtractor_16bit_seq
  import sub16_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,
  parameter int DIGIT = SUB_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow,
  output state_t           dbg_state
);

  localparam int DIGITS = WIDTH / DIGIT;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             borrow_q;
  logic [CW-1:0]    count;
  logic             last_slice;
  logic [DIGIT-1:0] a_s;
  logic [DIGIT-1:0] b_s;
  logic [DIGIT-1:0] d_s;
  logic             bout_s;

  assign last_slice = (count == CW'(DIGITS - 1));
  assign a_s        = a_q[count*DIGIT +: DIGIT];
  assign b_s        = b_q[count*DIGIT +: DIGIT];
  assign dbg_state  = state;

  // The single slice subtractor is reused every CALC cycle, steered by count.
  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_s  (a_s),
    .b_s  (b_s),
    .bin  (borrow_q),
    .d_s  (d_s),
    .bout (bout_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs; both readies come from state only.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CALC;
      end
      CALC: begin
        if (last_slice) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, slice-by-slice result build and final flag capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      count    <= '0;
      diff     <= '0;
      bout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            count    <= '0;
          end
        end
        CALC: begin
          diff[count*DIGIT +: DIGIT] <= d_s;
          borrow_q                   <= bout_s;
          count                      <= count + CW'(1);
          if (last_slice) begin
            bout     <= bout_s;
            overflow <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                        (d_s[DIGIT-1] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_16bit_seq.sv
// Bench for subtractor_16bit_seq: directed corner cases, backpressure,
// mid-operation reset and a randomized run against a reference model.
module tb_subtractor_16bit_seq;
  import sub16_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         overflow;
  state_t       dbg_state;

  int checks   = 0;
  int failures = 0;

  // Expected {overflow, bout, diff} per accepted operation.
  logic [W+1:0] exp_q[$];

  subtractor_16bit_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
    logic [W:0]   t;
    logic [W-1:0] d;
    logic         ov;
    t  = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    d  = t[W-1:0];
    ov = (ma[W-1] != mb[W-1]) && (d[W-1] != ma[W-1]);
    return {ov, t[W], d};
  endfunction

  // Advance one cycle and land 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer operands and wait for the accepting edge (bounded).
  task automatic drive_operands(input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic vbin, output bit ok);
    bit rdy;
    ok       = 1'b0;
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    bin      = vbin;
    for (int i = 0; i < 30; i++) begin
      rdy = in_ready;
      step();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    bin      = 1'($urandom);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready never seen high, required within 30 cycles");
    end
  endtask

  // Full operation: push expectation, drive, wait result, hold off for
  // 'hold' cycles, then pop and compare at the handshake.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin,
                        input int hold, input bit check_lat, input string name);
    bit           ok;
    int           lat;
    logic [W+1:0] exp;
    logic [W+1:0] held;
    exp_q.push_back(model(va, vb, vbin));
    drive_operands(va, vb, vbin, ok);
    if (!ok) begin
      void'(exp_q.pop_front());
      return;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: out_valid=0 after %0d cycles, required 1", name, lat);
      void'(exp_q.pop_front());
      return;
    end
    if (check_lat) begin
      checks++;
      if (lat !== 4) begin
        failures++;
        $display("FAIL %s_latency: got %0d cycles, required 4", name, lat);
      end
    end
    held = {overflow, bout, diff};
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a        = W'($urandom);
      b        = W'($urandom);
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {overflow, bout, diff} !== held) begin
        failures++;
        $display("FAIL %s_hold: out_valid=%b in_ready=%b res=%h, required 1 0 %h",
                 name, out_valid, in_ready, {overflow, bout, diff}, held);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    exp       = exp_q.pop_front();
    checks++;
    if ({overflow, bout, diff} !== exp) begin
      failures++;
      $display("FAIL %s_result: a=%h b=%h bin=%b got ov=%b bout=%b diff=%h, required ov=%b bout=%b diff=%h",
               name, va, vb, vbin, overflow, bout, diff, exp[W+1], exp[W], exp[W-1:0]);
    end
    step();
    out_ready = 1'($urandom_range(0, 1));
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b, required 0 1", name, out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0 || bout !== 1'b0 ||
        overflow !== 1'b0 || dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b diff=%h bout=%b ov=%b state=%0d, required 1 0 0000 0 0 0",
               in_ready, out_valid, diff, bout, overflow, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b1, "signed_min_minus_one");
    run_op(16'h0000, 16'h0001, 1'b0, 0, 1'b1, "zero_minus_one");
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b1, "max_minus_neg1");
    run_op(16'h1234, 16'h1234, 1'b1, 0, 1'b1, "equal_with_bin");
    run_op(16'h0001, 16'h0000, 1'b1, 0, 1'b1, "one_minus_bin");
    run_op(16'h0000, 16'h0000, 1'b0, 0, 1'b1, "zero_zero");
  endtask

  task automatic test_backpressure();
    run_op(16'hA5A5, 16'h5A5A, 1'b0, 10, 1'b1, "backpressure");
  endtask

  task automatic test_back_to_back();
    run_op(16'h0F0F, 16'h00F1, 1'b1, 0, 1'b0, "b2b_0");
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "b2b_1");
    run_op(16'h8000, 16'h7FFF, 1'b1, 0, 1'b0, "b2b_2");
  endtask

  task automatic test_reset_mid_op();
    bit ok;
    drive_operands(16'hBEEF, 16'h1234, 1'b1, ok);
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== '0 || bout !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_calc: in_ready=%b out_valid=%b diff=%h bout=%b ov=%b, required 1 0 0000 0 0",
               in_ready, out_valid, diff, bout, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    run_op(16'h00FF, 16'h0F00, 1'b0, 0, 1'b1, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'b0, "random");
    end
  endtask

  // Sequence of scenarios and the final report.
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
